stack_mem_arbiter: RTL
======================

Name: stack_mem_arbiter

Overview:
- Parametrised multi-master memory arbiter with an integrated 6502 hardware stack unit.
- Arbitrates NUM_CH request channels (CPU, DMA, debug, ...) plus a dedicated stack channel onto one external byte bus.
- Inserts per-region wait states, decodes RAM/ROM/IO selects, and maintains a loadable SP with sticky overflow/underflow flags.
- Sits between the CPU core/DMA and the board memory wrapper.

Parameters:
ADDR_W, 16, address width (>=8; region decode uses the top 2 bits).
DATA_W, 8, data width.
NUM_CH, 2, number of request channels (1..8).
STACK_PAGE, 8'h01, stack page; address high bits.
SP_RESET, 8'hFD, SP value after reset.
RAM_WAIT, 0, extra wait cycles for RAM.
IO_WAIT, 2, extra wait cycles for IO.
ROM_WAIT, 1, extra wait cycles for ROM.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_CH  per-channel request, held until req_ready
req_we  in  NUM_CH  1=write, 0=read
req_addr  in  NUM_CH*ADDR_W  packed addresses, ch0 in the LSBs
req_wdata  in  NUM_CH*DATA_W  packed write data
req_ready  out  NUM_CH  one-cycle accept pulse per channel
rsp_valid  out  NUM_CH  one-cycle completion pulse per channel
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
stack_push  in  1  push request, held until stack_ack
stack_pop  in  1  pop request, held until stack_ack
stack_wdata  in  DATA_W  push data
stack_load  in  1  load SP from stack_load_val
stack_load_val  in  8  new SP value
stack_flag_clr  in  1  clears the sticky flags
stack_ack  out  1  one-cycle stack completion pulse
stack_rdata  out  DATA_W  pop data, valid with stack_ack
sp  out  8  stack pointer
stack_overflow  out  1  sticky flag
stack_underflow  out  1  sticky flag
ext_addr  out  ADDR_W  external address
ext_wdata  out  DATA_W  external write data
ext_rdata  in  DATA_W  external read data
ext_oe  out  1  read strobe
ext_we  out  1  write strobe
ram_select  out  1  RAM region select
rom_select  out  1  ROM region select
io_select  out  1  IO region select

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, sp=SP_RESET, flags=0, round-robin pointer set so ch0 wins first.
  - All pulses, strobes and selects 0; ext_addr/ext_wdata/rsp_rdata/stack_rdata=0.
  - Reset mid-transaction aborts it; no rsp_valid or stack_ack is issued for it.
- Memory map on latched address top 2 bits: 00/01 -> RAM; 10 -> IO; 11 -> ROM. Wait count W = the region's *_WAIT value.
- FSM states: IDLE, ACCESS, DONE.
- IDLE priority (one decision per cycle):
  - stack_load first: sp<=stack_load_val next cycle; remain IDLE; no bus activity.
  - Then stack op: push beats pop if both are high; the pop stays pending.
  - Then channels, round-robin starting after the last granted channel.
  - A channel grant pulses req_ready[i] in the same IDLE cycle and latches addr/we/wdata; go to ACCESS.
- Stack grant:
  - Push address = {STACK_PAGE, sp}, write.
  - Pop address = {STACK_PAGE, sp+1 mod 256}, read.
  - Go to ACCESS.
- ACCESS lasts W+1 cycles; a down-counter runs W..0.
  - ext_addr/ext_wdata held stable; region select high.
  - ext_oe=1 for reads, ext_we=1 for writes, for all ACCESS cycles.
  - ext_rdata is sampled on the last ACCESS cycle.
- DONE (one cycle): strobes and selects 0, then return to IDLE.
  - Channel op: rsp_valid[granted]=1; rsp_rdata=sampled data (reads; holds the previous value for writes).
  - Stack op: stack_ack=1; stack_rdata=sampled data for pops.
  - SP update in DONE: push sp<=sp-1; pop sp<=sp+1 (mod 256).
- Latency: grant at cycle T -> response pulse at T+W+2. Minimum back-to-back issue interval is W+3 cycles.
- Stack boundaries:
  - Push with sp==8'h00: write completes, sp wraps to 8'hFF, stack_overflow<=1.
  - Pop with sp==8'hFF: read from {page,8'h00}, sp wraps to 8'h00, stack_underflow<=1.
  - Flags are sticky until stack_flag_clr. If a set event and a clear coincide, set wins.
- Handshake rules:
  - A request dropped before its accept is simply not served.
  - Request signals changing after accept have no effect.
  - stack_load outside IDLE is ignored; the requester must hold it until sp changes.
- req_ready and rsp_valid are one-hot or all-zero; never more than one transaction is in flight.

Test Plan:
- Reset, then ch0 read of 16'h0123, RAM_WAIT=0, ext_rdata=8'h5A -> req_ready[0] at T; ext_oe+ram_select for 1 cycle; rsp_valid[0] with 8'h5A at T+2; sp=8'hFD.
- ch1 write of 8'h77 to 16'h8001 (IO, W=2) -> ext_we+io_select for 3 cycles with addr 8001/data 77; rsp_valid[1] at T+4.
- ch0 and ch1 continuously valid -> grants alternate 0,1,0,1. Adding stack_push -> stack is granted at the next IDLE ahead of both channels.
- stack_load 8'h00, push 8'hAB -> write to 16'h0100, sp=8'hFF, stack_overflow=1. Pop -> read from 16'h0100, returns 8'hAB, sp=8'h00, stack_underflow=1. stack_flag_clr -> both flags 0.
- stack_push and stack_pop high together with sp=8'h10 -> push served first (sp->8'h0F), then pop reads 16'h0110 (sp->8'h10).
- ROM read of 16'hC000 (W=1), rst_n low during the second ACCESS cycle -> no rsp_valid; strobes 0 next cycle; sp=8'hFD; a new request is accepted normally afterwards.

Source files
------------

// File: rtl/stack_mem_arbiter_if.sv
// Channel-side request/response bundle of stack_mem_arbiter.
// Per-channel fields are packed, with channel 0 in the LSBs.
interface stack_mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/stack_mem_arbiter.sv
// Round-robin multi-channel byte-bus arbiter with an integrated 6502-style stack unit,
// per-region wait states and RAM/ROM/IO select decode.
module stack_mem_arbiter #(
    parameter int         ADDR_W     = 16,
    parameter int         DATA_W     = 8,
    parameter int         NUM_CH     = 2,
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] SP_RESET   = 8'hFD,
    parameter int         RAM_WAIT   = 0,
    parameter int         IO_WAIT    = 2,
    parameter int         ROM_WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_mem_arbiter_if.slave bus,
    input  logic              stack_push,
    input  logic              stack_pop,
    input  logic [DATA_W-1:0] stack_wdata,
    input  logic              stack_load,
    input  logic [7:0]        stack_load_val,
    input  logic              stack_flag_clr,
    output logic              stack_ack,
    output logic [DATA_W-1:0] stack_rdata,
    output logic [7:0]        sp,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              ext_oe,
    output logic              ext_we,
    output logic              ram_select,
    output logic              rom_select,
    output logic              io_select
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        sp_reg;
    logic              ovf_reg, unf_reg;
    logic [CH_W-1:0]   rr_ptr_reg, gnt_idx_reg;
    logic [7:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, rsp_rdata_reg, stack_rdata_reg;
    logic              we_reg, is_stack_reg, is_push_reg;

    logic              do_load, grant_stack, grant_push, grant_ch;
    logic              found_hi, found_lo;
    logic [CH_W-1:0]   hi_idx, lo_idx, cand_idx;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_addr[gi]       = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi]      = bus.req_wdata[gi*DATA_W +: DATA_W];
            assign bus.req_ready[gi] = grant_ch && (cand_idx == CH_W'(gi));
            assign bus.rsp_valid[gi] = (state_reg == DONE) && !is_stack_reg
                                       && (gnt_idx_reg == CH_W'(gi));
        end
    endgenerate

    function automatic logic [7:0] region_wait(input logic [1:0] top);
        case (top)
            2'b10:   return 8'(IO_WAIT);
            2'b11:   return 8'(ROM_WAIT);
            default: return 8'(RAM_WAIT);
        endcase
    endfunction

    always_comb begin
        state_next  = state_reg;
        do_load     = 1'b0;
        grant_stack = 1'b0;
        grant_push  = 1'b0;
        grant_ch    = 1'b0;
        found_hi    = 1'b0;
        found_lo    = 1'b0;
        hi_idx      = '0;
        lo_idx      = '0;
        // Round robin: first requester above the last grant, else the lowest one.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_hi && bus.req_valid[i] && (CH_W'(i) > rr_ptr_reg)) begin
                found_hi = 1'b1;
                hi_idx   = CH_W'(i);
            end
            if (!found_lo && bus.req_valid[i] && (CH_W'(i) <= rr_ptr_reg)) begin
                found_lo = 1'b1;
                lo_idx   = CH_W'(i);
            end
        end
        cand_idx = found_hi ? hi_idx : lo_idx;

        case (state_reg)
            IDLE: begin
                if (stack_load) begin
                    do_load = 1'b1;
                end else if (stack_push || stack_pop) begin
                    grant_stack = 1'b1;
                    grant_push  = stack_push;
                    state_next  = ACCESS;
                end else if (found_hi || found_lo) begin
                    grant_ch   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  if (cnt_reg == 8'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (grant_push)
            addr_next = ADDR_W'({STACK_PAGE, sp_reg});
        else if (grant_stack)
            addr_next = ADDR_W'({STACK_PAGE, sp_reg + 8'd1});
        else
            addr_next = ch_addr[cand_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sp_reg          <= SP_RESET;
            ovf_reg         <= 1'b0;
            unf_reg         <= 1'b0;
            rr_ptr_reg      <= CH_W'(NUM_CH - 1);
            gnt_idx_reg     <= '0;
            cnt_reg         <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rsp_rdata_reg   <= '0;
            stack_rdata_reg <= '0;
            we_reg          <= 1'b0;
            is_stack_reg    <= 1'b0;
            is_push_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (do_load)
                sp_reg <= stack_load_val;

            if (grant_stack || grant_ch) begin
                addr_reg     <= addr_next;
                wdata_reg    <= grant_stack ? stack_wdata : ch_wdata[cand_idx];
                we_reg       <= grant_stack ? grant_push : bus.req_we[cand_idx];
                is_stack_reg <= grant_stack;
                is_push_reg  <= grant_push;
                cnt_reg      <= region_wait(addr_next[ADDR_W-1 -: 2]);
                if (grant_ch) begin
                    gnt_idx_reg <= cand_idx;
                    rr_ptr_reg  <= cand_idx;
                end
            end

            if (state_reg == ACCESS) begin
                if (cnt_reg != 8'd0)
                    cnt_reg <= cnt_reg - 8'd1;
                else if (!we_reg) begin
                    if (is_stack_reg) stack_rdata_reg <= ext_rdata;
                    else              rsp_rdata_reg   <= ext_rdata;
                end
            end

            // Clear first so a coincident boundary event below takes precedence.
            if (stack_flag_clr) begin
                ovf_reg <= 1'b0;
                unf_reg <= 1'b0;
            end
            if ((state_reg == DONE) && is_stack_reg) begin
                if (is_push_reg) begin
                    sp_reg <= sp_reg - 8'd1;
                    if (sp_reg == 8'h00) ovf_reg <= 1'b1;
                end else begin
                    sp_reg <= sp_reg + 8'd1;
                    if (sp_reg == 8'hFF) unf_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign stack_rdata     = stack_rdata_reg;
    assign stack_ack       = (state_reg == DONE) && is_stack_reg;
    assign sp              = sp_reg;
    assign stack_overflow  = ovf_reg;
    assign stack_underflow = unf_reg;
    assign ext_addr        = addr_reg;
    assign ext_wdata       = wdata_reg;
    assign ext_oe          = (state_reg == ACCESS) && !we_reg;
    assign ext_we          = (state_reg == ACCESS) && we_reg;
    assign ram_select      = (state_reg == ACCESS) && !addr_reg[ADDR_W-1];
    assign io_select       = (state_reg == ACCESS) && (addr_reg[ADDR_W-1 -: 2] == 2'b10);
    assign rom_select      = (state_reg == ACCESS) && (addr_reg[ADDR_W-1 -: 2] == 2'b11);
endmodule
